// File: rtl/llrf_afe_package.sv
// rtl/llrf_afe_package.sv - shared LLRF AFE types, step indices and helpers
package llrf_afe_package;

  localparam int unsigned INIT_STEPS_MAX = 16;

  localparam logic [3:0] STEP_JC       = 4'd0;
  localparam logic [3:0] STEP_DDS_SYNC = 4'd1;
  localparam logic [3:0] STEP_B2F      = 4'd2;
  localparam logic [3:0] STEP_PHADJ    = 4'd3;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    GUARD,
    START,
    WAIT,
    SETTLE,
    NEXT,
    DONE,
    FAIL
  } init_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterised-width two-flop synchroniser
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/llrf_init_seq.sv
// rtl/llrf_init_seq.sv - power-up / re-init sequencer for the LLRF AFE stage controllers
module llrf_init_seq
  import llrf_afe_package::*;
#(
  parameter int unsigned N_STEPS     = 8,
  parameter logic [31:0] TIMEOUT_CYC = 32'd100_000_000,
  parameter logic [15:0] SETTLE_CYC  = 16'd1000
) (
  input  logic               sys_clk,
  input  logic               init_reset,
  input  logic               restart,
  input  logic [N_STEPS-1:0] step_en,
  input  logic [N_STEPS-1:0] step_active,
  input  logic [N_STEPS-1:0] step_ready,
  output logic [N_STEPS-1:0] step_start,
  output logic [3:0]         cur_step,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [3:0]         err_step
);

  init_state_t        state_q, state_d;
  logic [3:0]         cur_q, cur_d;
  logic [3:0]         err_step_q, err_step_d;
  logic [31:0]        tmo_q, tmo_d;
  logic [15:0]        stl_q, stl_d;
  logic [N_STEPS-1:0] start_q, start_d;
  logic               auto_q;

  logic [N_STEPS-1:0]        active_s, ready_s;
  logic [INIT_STEPS_MAX-1:0] en_w, active_w, ready_w;
  logic                      tmo_hit;
  logic                      settle_end;

  sync_2ff #(.WIDTH(N_STEPS)) u_sync_active (
    .clk_i (sys_clk),
    .rst_i (init_reset),
    .d_i   (step_active),
    .q_o   (active_s)
  );

  sync_2ff #(.WIDTH(N_STEPS)) u_sync_ready (
    .clk_i (sys_clk),
    .rst_i (init_reset),
    .d_i   (step_ready),
    .q_o   (ready_s)
  );

  // Widen to the full 16-step space so cur_q can index directly.
  assign en_w     = INIT_STEPS_MAX'(step_en);
  assign active_w = INIT_STEPS_MAX'(active_s);
  assign ready_w  = INIT_STEPS_MAX'(ready_s);

  assign tmo_hit    = (tmo_q >= (TIMEOUT_CYC - 32'd1));
  assign settle_end = (stl_q >= (SETTLE_CYC - 16'd1));

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    err_step_d = err_step_q;
    tmo_d      = tmo_q;
    stl_d      = stl_q;

    case (state_q)
      IDLE: begin
        if (auto_q || restart) begin
          state_d    = CHECK;
          cur_d      = STEP_JC;
          err_step_d = '0;
        end
      end

      CHECK: begin
        if (!en_w[cur_q]) begin
          state_d = NEXT;
        end else begin
          state_d = GUARD;
          tmo_d   = '0;
        end
      end

      // A stage still busy from a previous run must drop active before it is started again.
      GUARD: begin
        tmo_d = sat_inc32(tmo_q);
        if (!active_w[cur_q]) begin
          state_d = START;
        end else if (tmo_hit) begin
          state_d    = FAIL;
          err_step_d = cur_q;
        end
      end

      START: begin
        state_d = WAIT;
      end

      // Ready is checked before the timeout so a same-cycle ready still passes.
      WAIT: begin
        tmo_d = sat_inc32(tmo_q);
        if (ready_w[cur_q]) begin
          stl_d   = '0;
          state_d = (SETTLE_CYC == 16'd0) ? NEXT : SETTLE;
        end else if (tmo_hit) begin
          state_d    = FAIL;
          err_step_d = cur_q;
        end
      end

      SETTLE: begin
        if (settle_end) begin
          state_d = NEXT;
        end else begin
          stl_d = stl_q + 16'd1;
        end
      end

      NEXT: begin
        if (cur_q == 4'(N_STEPS - 1)) begin
          state_d = DONE;
        end else begin
          cur_d   = cur_q + 4'd1;
          state_d = CHECK;
        end
      end

      DONE, FAIL: begin
        if (restart) begin
          state_d    = CHECK;
          cur_d      = STEP_JC;
          err_step_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    for (int i = 0; i < int'(N_STEPS); i++) begin
      start_d[i] = (state_d == START) && (cur_q == 4'(i));
    end
  end

  always_ff @(posedge sys_clk or posedge init_reset) begin
    if (init_reset) begin
      state_q    <= IDLE;
      cur_q      <= STEP_JC;
      err_step_q <= '0;
      tmo_q      <= '0;
      stl_q      <= '0;
      start_q    <= '0;
      auto_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      err_step_q <= err_step_d;
      tmo_q      <= tmo_d;
      stl_q      <= stl_d;
      start_q    <= start_d;
      auto_q     <= 1'b0;
    end
  end

  assign step_start = start_q;
  assign cur_step   = cur_q;
  assign err_step   = err_step_q;
  assign busy       = (state_q != IDLE) && (state_q != DONE) && (state_q != FAIL);
  assign done       = (state_q == DONE);
  assign error      = (state_q == FAIL);

endmodule

// File: tb/tb_llrf_init_seq.sv
// tb/tb_llrf_init_seq.sv - self-checking bench for llrf_init_seq
module tb_llrf_init_seq;

  localparam int N = 8;
  localparam int T = 200;
  localparam int S = 1000;

  logic         sys_clk;
  logic         init_reset;
  logic         restart;
  logic [N-1:0] step_en;
  logic [N-1:0] step_active;
  logic [N-1:0] step_ready;
  logic [N-1:0] step_start;
  logic [3:0]   cur_step;
  logic         busy;
  logic         done;
  logic         error;
  logic [3:0]   err_step;

  llrf_init_seq #(
    .N_STEPS     (N),
    .TIMEOUT_CYC (32'(T)),
    .SETTLE_CYC  (16'(S))
  ) dut (
    .sys_clk     (sys_clk),
    .init_reset  (init_reset),
    .restart     (restart),
    .step_en     (step_en),
    .step_active (step_active),
    .step_ready  (step_ready),
    .step_start  (step_start),
    .cur_step    (cur_step),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_step    (err_step)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs, produced by walking the sequence rules step by step.
  logic [N-1:0] exp_start;
  logic [3:0]   exp_cur;
  logic         exp_busy, exp_done, exp_err;
  logic [3:0]   exp_err_step;
  logic [N-1:0] act_h1, act_h2, rdy_h1, rdy_h2, act_seen, rdy_seen;
  bit           m_abort;
  bit           model_live;

  logic [18:0] dut_vec, exp_vec;
  assign dut_vec = {step_start, cur_step, busy, done, error, err_step};
  assign exp_vec = {exp_start, exp_cur, exp_busy, exp_done, exp_err, exp_err_step};

  task automatic tick();
    @(posedge sys_clk);
    if (init_reset) begin
      m_abort = 1'b1;
    end else begin
      act_seen = act_h2;
      rdy_seen = rdy_h2;
      act_h2   = act_h1;
      rdy_h2   = rdy_h1;
      act_h1   = step_active;
      rdy_h1   = step_ready;
    end
  endtask

  task automatic run_seq();
    int used;
    exp_busy     = 1'b1;
    exp_done     = 1'b0;
    exp_err      = 1'b0;
    exp_err_step = 4'd0;
    exp_start    = '0;
    for (int s = 0; s < N; s++) begin
      exp_cur = 4'(s);
      tick(); if (m_abort) return;
      if (step_en[s]) begin
        used = 0;
        while (1) begin
          tick(); if (m_abort) return;
          used++;
          if (!act_seen[s]) break;
          if (used >= T) begin
            exp_busy = 1'b0; exp_err = 1'b1; exp_err_step = 4'(s);
            return;
          end
        end
        exp_start    = '0;
        exp_start[s] = 1'b1;
        tick(); if (m_abort) return;
        exp_start = '0;
        while (1) begin
          tick(); if (m_abort) return;
          used++;
          if (rdy_seen[s]) break;
          if (used >= T) begin
            exp_busy = 1'b0; exp_err = 1'b1; exp_err_step = 4'(s);
            return;
          end
        end
        for (int k = 0; k < S; k++) begin
          tick(); if (m_abort) return;
        end
      end
      tick(); if (m_abort) return;
    end
    exp_busy = 1'b0;
    exp_done = 1'b1;
  endtask

  initial begin : model
    forever begin
      exp_start = '0; exp_cur = 4'd0; exp_busy = 1'b0;
      exp_done = 1'b0; exp_err = 1'b0; exp_err_step = 4'd0;
      act_h1 = '0; act_h2 = '0; rdy_h1 = '0; rdy_h2 = '0;
      act_seen = '0; rdy_seen = '0;
      m_abort = 1'b0;
      model_live = 1'b0;
      do @(posedge sys_clk); while (init_reset);
      model_live = 1'b1;
      act_h1 = step_active;
      rdy_h1 = step_ready;
      run_seq();
      while (!m_abort) begin
        tick();
        if (!m_abort && restart) run_seq();
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge sys_clk);
      if (!init_reset && model_live) chk("cycle_outputs", 32'(dut_vec), 32'(exp_vec));
    end
  end

  // Stage responders: one-cycle ready pulse rdy_dly cycles after each start pulse.
  int rdy_dly [N];
  int rdy_cnt [N];
  bit rdy_pend [N];
  int pulse_cnt [N];

  initial begin : responder
    step_ready = '0;
    for (int i = 0; i < N; i++) rdy_pend[i] = 1'b0;
    forever begin
      @(negedge sys_clk);
      step_ready = '0;
      for (int i = 0; i < N; i++) begin
        if (init_reset) begin
          rdy_pend[i] = 1'b0;
        end else if (rdy_pend[i]) begin
          rdy_cnt[i]--;
          if (rdy_cnt[i] == 0) begin
            step_ready[i] = 1'b1;
            rdy_pend[i]   = 1'b0;
          end
        end else if (step_start[i] && rdy_dly[i] > 0) begin
          rdy_pend[i] = 1'b1;
          rdy_cnt[i]  = rdy_dly[i];
        end
      end
    end
  end

  initial begin : pulse_mon
    for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
    forever begin
      @(negedge sys_clk);
      if (!init_reset)
        for (int i = 0; i < N; i++) if (step_start[i]) pulse_cnt[i]++;
    end
  end

  task automatic clear_pulses();
    for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
  endtask

  // kind 0: step_start[idx], 1: done, 2: error; n = negedges waited, -1 on expiry
  task automatic wait_cond(input int kind, input int idx, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge sys_clk);
      if ((kind == 0 && step_start[idx]) || (kind == 1 && done) || (kind == 2 && error)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_restart();
    @(negedge sys_clk); restart = 1'b1;
    @(negedge sys_clk); restart = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int sum;
    init_reset  = 1'b1;
    restart     = 1'b0;
    step_en     = 8'h01;
    step_active = '0;
    for (int i = 0; i < N; i++) rdy_dly[i] = 20;

    // Reset state, then auto-run with only step 0 enabled.
    repeat (3) @(negedge sys_clk);
    chk("reset_state", 32'(dut_vec), 32'd0);
    init_reset = 1'b0;
    wait_cond(0, 0, 20, n);
    chk("autorun_start_latency", n, 3);
    wait_cond(1, 0, 3000, n);
    chk("t1_start_to_done", n, 1038);
    chk("t1_flags", {busy, done, error}, 3'b010);

    // restart while busy must not disturb the run
    pulse_restart();
    wait_cond(0, 0, 20, n);
    chk("restart_start_latency", n, 2);
    repeat (5) @(negedge sys_clk);
    pulse_restart();
    chk("busy_restart_ignored", {busy, cur_step}, {1'b1, 4'd0});
    wait_cond(1, 0, 3000, n);
    chk("busy_restart_done_time", n, 1031);

    // ready arriving exactly on the timeout cycle wins
    rdy_dly[0] = T - 3;
    pulse_restart();
    wait_cond(0, 0, 20, n);
    chk("tie_start_latency", n, 2);
    wait_cond(1, 0, 3000, n);
    chk("tie_start_to_done", n, 1215);
    chk("tie_no_error", error, 1'b0);
    rdy_dly[0] = 20;

    // all-zero enable mask
    step_en = 8'h00;
    clear_pulses();
    pulse_restart();
    wait_cond(1, 0, 100, n);
    chk("zero_mask_done_time", n, 16);
    sum = 0;
    for (int i = 0; i < N; i++) sum += pulse_cnt[i];
    chk("zero_mask_no_starts", sum, 0);

    // step 2 never answers
    step_en    = 8'h05;
    rdy_dly[2] = -1;
    clear_pulses();
    pulse_restart();
    wait_cond(0, 2, 3000, n);
    chk("fail_step2_started", (n > 0), 1'b1);
    wait_cond(2, 0, 400, n);
    chk("fail_start_to_error", n, 200);
    chk("fail_flags", {error, done, busy, err_step}, {1'b1, 1'b0, 1'b0, 4'd2});
    repeat (20) @(negedge sys_clk);
    sum = 0;
    for (int i = 3; i < N; i++) sum += pulse_cnt[i];
    chk("fail_no_later_starts", sum, 0);
    chk("fail_sticky", {error, err_step}, {1'b1, 4'd2});

    // restart after the failure with stage 2 responsive
    rdy_dly[2] = 20;
    pulse_restart();
    chk("restart_clears_error", {error, busy, cur_step, err_step}, {1'b0, 1'b1, 4'd0, 4'd0});
    wait_cond(1, 0, 5000, n);
    chk("restart_rerun_done", (n > 0), 1'b1);
    chk("restart_rerun_no_error", error, 1'b0);

    // stage 0 still active for 50 cycles after reset release
    step_en        = 8'h01;
    step_active[0] = 1'b1;
    @(negedge sys_clk);
    #2 init_reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    init_reset = 1'b0;
    clear_pulses();
    repeat (50) @(negedge sys_clk);
    chk("guard_held_no_start", pulse_cnt[0], 0);
    step_active[0] = 1'b0;
    wait_cond(0, 0, 20, n);
    chk("guard_release_latency", n, 3);
    wait_cond(1, 0, 3000, n);
    chk("guard_run_done", (n > 0), 1'b1);

    // reset in the middle of step 1's wait
    step_en    = 8'h03;
    rdy_dly[1] = 150;
    clear_pulses();
    pulse_restart();
    wait_cond(0, 1, 3000, n);
    chk("midreset_step1_started", (n > 0), 1'b1);
    repeat (30) @(negedge sys_clk);
    chk("midreset_one_start1", pulse_cnt[1], 1);
    #2 init_reset = 1'b1;
    #1 chk("midreset_outputs_zero", 32'(dut_vec), 32'd0);
    clear_pulses();
    repeat (3) @(negedge sys_clk);
    init_reset = 1'b0;
    wait_cond(0, 0, 20, n);
    chk("midreset_restart_step0", n, 3);
    chk("midreset_no_reissue1", pulse_cnt[1], 0);
    wait_cond(1, 0, 5000, n);
    chk("midreset_run_done", (n > 0), 1'b1);

    repeat (3) @(negedge sys_clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
